// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I sequencer
package riscv_ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [1:0] SRC_RS2 = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;
    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR} iclass_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational IR field decode into class, ALU controls and legality
module mc_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output iclass_t    cls,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src,
    output logic       illegal
);
    logic [3:0] f3_op;
    logic       is_r;
    assign is_r = opc == OP_R;
    always_comb begin
        cls = C_R;
        illegal = 1'b0;
        case (opc)
            OP_R:      cls = C_R;
            OP_I:      cls = C_I;
            OP_LOAD:   cls = C_LOAD;
            OP_STORE:  cls = C_STORE;
            OP_BRANCH: cls = C_BRANCH;
            OP_JAL:    cls = C_JAL;
            OP_JALR:   cls = C_JALR;
            default:   illegal = 1'b1;
        endcase
        if (is_r && f7 != 7'b0000000 && !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
            illegal = 1'b1;
    end
    // R-type selects sub/sra with funct7[5]; I-type shifts use the whole funct7 field
    always_comb begin
        f3_op = ALU_ADD;
        case (f3)
            3'b000: f3_op = (is_r && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: f3_op = ALU_SLL;
            3'b010: f3_op = ALU_SLT;
            3'b011: f3_op = ALU_SLTU;
            3'b100: f3_op = ALU_XOR;
            3'b101: f3_op = (is_r ? f7[5] : |f7) ? ALU_SRA : ALU_SRL;
            3'b110: f3_op = ALU_OR;
            3'b111: f3_op = ALU_AND;
        endcase
    end
    assign alu_op  = (cls == C_R || cls == C_I) ? f3_op : (cls == C_BRANCH) ? ALU_SUB : ALU_ADD;
    assign alu_src = (cls == C_R || cls == C_BRANCH) ? SRC_RS2 : SRC_IMM;
endmodule

// File: rtl/multicycle_seq_ctrl.sv
// multicycle_seq_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving a shared ALU and memory port
module multicycle_seq_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_instr,
    output logic        ir_write,
    output logic [1:0]  alu_src,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        instr_retired,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    logic [2:0]        state, state_nx;
    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause;
    iclass_t           cls;
    logic [3:0]        dec_op;
    logic [1:0]        dec_src;
    logic              illegal, stall, timeout, retire, is_jmp, is_ctl, alu_on;
    logic              unused_rdata;
    assign unused_rdata = ^{mem_rdata[24:15], mem_rdata[11:7]};
    mc_decode u_decode (
        .opc(opc), .f3(f3), .f7(f7),
        .cls(cls), .alu_op(dec_op), .alu_src(dec_src), .illegal(illegal)
    );
    assign is_jmp  = cls == C_JAL || cls == C_JALR;
    assign is_ctl  = is_jmp || cls == C_BRANCH;
    assign alu_on  = state == S_EXEC || state == S_MEM;
    assign stall   = mem_req && !mem_ready;
    assign timeout = (MAX_WAIT > 0) && stall && wait_cnt == WAIT_W'(MAX_WAIT - 1);
    assign mem_req   = state == S_FETCH || state == S_MEM;
    assign mem_instr = state == S_FETCH;
    assign mem_we    = state == S_MEM && cls == C_STORE;
    assign ir_write  = state == S_FETCH && mem_ready;
    assign alu_op    = alu_on ? dec_op : ALU_ADD;
    assign alu_src   = alu_on ? dec_src : SRC_RS2;
    assign retire    = state == S_WB || (state == S_EXEC && is_ctl) || (state == S_MEM && mem_ready && cls == C_STORE);
    assign reg_write = state == S_WB || (state == S_EXEC && is_jmp);
    assign wb_sel    = state == S_WB ? (cls == C_LOAD ? WB_MEM : WB_ALU) : (state == S_EXEC && is_jmp) ? WB_PC4 : WB_ALU;
    assign pc_write  = retire;
    assign pc_src    = state != S_EXEC ? PC_PLUS4 : cls == C_JALR ? PC_JALR :
                       (cls == C_JAL || (cls == C_BRANCH && br_taken)) ? PC_REL : PC_PLUS4;
    assign instr_retired = retire;
    assign trap       = state == S_TRAP;
    assign trap_cause = cause;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = en ? S_FETCH : S_IDLE;
            S_FETCH:  state_nx = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            S_DECODE: state_nx = illegal ? S_TRAP : S_EXEC;
            S_EXEC:   state_nx = (cls == C_R || cls == C_I) ? S_WB : (cls == C_LOAD || cls == C_STORE) ? S_MEM :
                                 en ? S_FETCH : S_IDLE;
            S_MEM:    state_nx = !mem_ready ? (timeout ? S_TRAP : S_MEM) : cls == C_LOAD ? S_WB : en ? S_FETCH : S_IDLE;
            S_WB:     state_nx = en ? S_FETCH : S_IDLE;
            default:  state_nx = S_TRAP;
        endcase
    end
    // Stall count restarts whenever the port is not stalled, which covers entry and every handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            opc      <= '0;
            f3       <= '0;
            f7       <= '0;
            wait_cnt <= '0;
            cause    <= CAUSE_NONE;
        end else begin
            state    <= state_nx;
            wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
            if (ir_write)
                {f7, f3, opc} <= {mem_rdata[31:25], mem_rdata[14:12], mem_rdata[6:0]};
            if (state_nx == S_TRAP && state != S_TRAP)
                cause <= state == S_DECODE ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
    end
endmodule
